// File: rtl/enet_wdog_pkg.sv
// Shared types and widths for the Ethernet PHY link watchdog.
package enet_wdog_pkg;

    localparam int RETRY_W = 3;
    localparam int EVT_W   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MONITOR = 3'd1;
    localparam logic [2:0] ST_ASSERT  = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_MONITOR = ST_MONITOR,
        S_ASSERT  = ST_ASSERT,
        S_RECOVER = ST_RECOVER,
        S_FAULT   = ST_FAULT
    } wdog_state_e;

endpackage

// File: rtl/enet_wdog_timer.sv
// Shared phase timer: clear, count-enable and equality terminal compare
// against a per-state limit supplied by the FSM.
module enet_wdog_timer #(
    parameter int CNT_W = 24
) (
    input  logic             tx_clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge tx_clk) begin
        if (reset || clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == limit);

endmodule

// File: rtl/enet_link_wdog.sv
// Ethernet PHY link watchdog: times out on rx silence, pulses phy_reset_n,
// waits for PHY recovery and parks in FAULT after MAX_RETRY retries.
// Optional timeout event counter enabled by ENET_WDOG_EVT_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for the upstream generator (gen_done)
// MONITOR | watching rx_activity, timer counts silence
// ASSERT  | phy_reset_n held low for PULSE_CYCLES
// RECOVER | PHY settling for RECOVER_CYCLES
// FAULT   | retries exhausted; only force_reset or reset leaves
module enet_link_wdog
    import enet_wdog_pkg::*;
#(
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int PULSE_CYCLES   = 250000,
    parameter int RECOVER_CYCLES = 2500000,
    parameter int MAX_RETRY      = 3
) (
    input  logic               tx_clk,
    input  logic               reset,
    input  logic               gen_done,
    input  logic               rx_activity,
    input  logic               force_reset,
    output logic               phy_reset_n,
    output logic               link_ok,
    output logic [RETRY_W-1:0] retry_count,
    output logic               fault,
    output logic [EVT_W-1:0]   wdog_evt_cnt
);

    wdog_state_e      state_q, state_d;
    logic             tc, timer_clr, timer_en;
    logic [CNT_W-1:0] limit;
    logic             act_hit, timeout_hit, retry_left;

    assign retry_left = (retry_count < RETRY_W'(MAX_RETRY));

    // gen_done drop and force_reset both outrank activity and timeout
    assign act_hit     = (state_q == S_MONITOR) && gen_done && !force_reset && rx_activity;
    assign timeout_hit = (state_q == S_MONITOR) && gen_done && !force_reset && !rx_activity && tc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (gen_done) state_d = S_MONITOR;
            S_MONITOR: begin
                if (!gen_done)
                    state_d = S_IDLE;
                else if (force_reset)
                    state_d = S_ASSERT;
                else if (timeout_hit)
                    state_d = retry_left ? S_ASSERT : S_FAULT;
            end
            S_ASSERT:  if (tc) state_d = gen_done ? S_RECOVER : S_IDLE;
            S_RECOVER: begin
                if (!gen_done)
                    state_d = S_IDLE;
                else if (tc)
                    state_d = S_MONITOR;
            end
            S_FAULT:   if (force_reset) state_d = S_ASSERT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        limit = '0;
        case (state_q)
            S_MONITOR: limit = CNT_W'(TIMEOUT_CYCLES - 1);
            S_ASSERT:  limit = CNT_W'(PULSE_CYCLES - 1);
            S_RECOVER: limit = CNT_W'(RECOVER_CYCLES - 1);
            default:   limit = '0;
        endcase
    end

    assign timer_clr = (state_d != state_q) || act_hit;
    assign timer_en  = (state_q == S_MONITOR) || (state_q == S_ASSERT) ||
                       (state_q == S_RECOVER);

    enet_wdog_timer #(.CNT_W(CNT_W)) u_timer (
        .tx_clk (tx_clk),
        .reset  (reset),
        .clr    (timer_clr),
        .en     (timer_en),
        .limit  (limit),
        .tc     (tc)
    );

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phy_reset_n <= 1'b1;
            link_ok     <= 1'b0;
            retry_count <= '0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phy_reset_n <= (state_d != S_ASSERT);
            fault       <= (state_d == S_FAULT);
            link_ok     <= (state_d == S_MONITOR) && (link_ok || act_hit);
            if ((state_q == S_FAULT) && force_reset)
                retry_count <= '0;
            else if (act_hit)
                retry_count <= '0;
            else if (timeout_hit && retry_left)
                retry_count <= retry_count + 1'b1;
        end
    end

`ifdef ENET_WDOG_EVT_CNT_EN
    logic [EVT_W-1:0] evt_q;

    always_ff @(posedge tx_clk) begin
        if (reset)
            evt_q <= '0;
        else if (timeout_hit && (evt_q != '1))
            evt_q <= evt_q + 1'b1;
    end

    assign wdog_evt_cnt = evt_q;
`else
    assign wdog_evt_cnt = '0;
`endif

endmodule

// File: tb/tb_enet_link_wdog.sv
// Self-checking bench for enet_link_wdog with a phase/time-left reference model.
module tb_enet_link_wdog;

    localparam int T  = 16;
    localparam int P  = 4;
    localparam int R  = 8;
    localparam int MR = 2;

    localparam int PH_IDLE = 0, PH_MON = 1, PH_PULSE = 2, PH_RECOV = 3, PH_FAULT = 4;

    logic        tx_clk = 1'b0;
    logic        reset, gen_done, rx_activity, force_reset;
    logic        phy_reset_n, link_ok, fault;
    logic [2:0]  retry_count;
    logic [15:0] wdog_evt_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_phase, m_left, m_retry, m_evt;
    bit m_link, m_fault, m_phy;

    enet_link_wdog #(
        .CNT_W(24), .TIMEOUT_CYCLES(T), .PULSE_CYCLES(P),
        .RECOVER_CYCLES(R), .MAX_RETRY(MR)
    ) dut (
        .tx_clk       (tx_clk),
        .reset        (reset),
        .gen_done     (gen_done),
        .rx_activity  (rx_activity),
        .force_reset  (force_reset),
        .phy_reset_n  (phy_reset_n),
        .link_ok      (link_ok),
        .retry_count  (retry_count),
        .fault        (fault),
        .wdog_evt_cnt (wdog_evt_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    // Model: a phase plus the number of cycles left before that phase expires.
    task automatic model_step();
        if (reset) begin
            m_phase = PH_IDLE; m_left = 0; m_retry = 0;
            m_link = 0; m_fault = 0; m_evt = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (gen_done) begin m_phase = PH_MON; m_left = T; end
                PH_MON: begin
                    if (!gen_done) begin
                        m_phase = PH_IDLE; m_link = 0;
                    end else if (force_reset) begin
                        m_phase = PH_PULSE; m_left = P; m_link = 0;
                    end else if (rx_activity) begin
                        m_left = T; m_link = 1; m_retry = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_evt < 65535) m_evt++;
                            m_link = 0;
                            if (m_retry < MR) begin
                                m_retry++; m_phase = PH_PULSE; m_left = P;
                            end else begin
                                m_phase = PH_FAULT; m_fault = 1;
                            end
                        end
                    end
                end
                PH_PULSE: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (gen_done) begin m_phase = PH_RECOV; m_left = R; end
                        else m_phase = PH_IDLE;
                    end
                end
                PH_RECOV: begin
                    if (!gen_done) m_phase = PH_IDLE;
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_phase = PH_MON; m_left = T; end
                    end
                end
                PH_FAULT: if (force_reset) begin
                    m_phase = PH_PULSE; m_left = P; m_retry = 0; m_fault = 0;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
        m_phy = (m_phase != PH_PULSE);
    endtask

    function automatic logic [21:0] exp_vec();
        logic [15:0] e;
`ifdef ENET_WDOG_EVT_CNT_EN
        e = m_evt[15:0];
`else
        e = 16'd0;
`endif
        return {m_phy, m_link, m_retry[2:0], m_fault, e};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {phy_reset_n, link_ok, retry_count, fault, wdog_evt_cnt};
    endfunction

    task automatic tick();
        @(posedge tx_clk);
        model_step();
        @(negedge tx_clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1; gen_done = 0; rx_activity = 0; force_reset = 0;
        repeat (3) tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; gen_done = 1; rx_activity = 1; force_reset = 1;
        repeat (3) tick();
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 3'd0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", dut_vec(), {1'b1, 1'b0, 3'd0, 1'b0, 16'd0});
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
        end
        reset = 0; gen_done = 0; rx_activity = 0; force_reset = 0;
    endtask

    task automatic test_power_up();
        int first_low = -1;
        int width = 0;
        do_reset();
        gen_done = 1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pwr_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (phy_reset_n === 1'b0) begin
                width++;
                if (first_low < 0) first_low = n;
            end
        end
        checks++;
        if (first_low != 17) begin
            errors++;
            $display("FAIL pwr_pulse_start got=%0d exp=17", first_low);
        end
        checks++;
        if (width != 4) begin
            errors++;
            $display("FAIL pwr_pulse_width got=%0d exp=4", width);
        end
        checks++;
        if (retry_count !== 3'd1) begin
            errors++;
            $display("FAIL pwr_retry got=%0d exp=1", retry_count);
        end
    endtask

    task automatic test_keep_alive();
        int bad_phy = 0;
        int bad_link = 0;
        do_reset();
        gen_done = 1;
        for (int i = 0; i < 200; i++) begin
            rx_activity = (i % 10 == 5);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL keep_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (phy_reset_n !== 1'b1) bad_phy++;
            if (i >= 5 && link_ok !== 1'b1) bad_link++;
        end
        rx_activity = 0;
        checks++;
        if (bad_phy != 0 || bad_link != 0) begin
            errors++;
            $display("FAIL keep_alive phy_low_cycles=%0d link_low_cycles=%0d exp=0,0", bad_phy, bad_link);
        end
        checks++;
        if (retry_count !== 3'd0) begin
            errors++;
            $display("FAIL keep_retry got=%0d exp=0", retry_count);
        end
    endtask

    task automatic test_exhaustion();
        int pulses = 0;
        bit prev_phy = 1;
        bit seen = 0;
        do_reset();
        gen_done = 1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL exh_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (prev_phy && phy_reset_n === 1'b0) pulses++;
            prev_phy = (phy_reset_n !== 1'b0);
            if (fault === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL exh_timeout fault never rose within 200 cycles got=0 exp=1");
        end
        checks++;
        if (pulses != 2 || phy_reset_n !== 1'b1 || retry_count !== 3'd2) begin
            errors++;
            $display("FAIL exh_state pulses=%0d phy=%b retry=%0d exp pulses=2 phy=1 retry=2",
                     pulses, phy_reset_n, retry_count);
        end
`ifdef ENET_WDOG_EVT_CNT_EN
        checks++;
        if (wdog_evt_cnt !== 16'd3) begin
            errors++;
            $display("FAIL exh_evt got=%0d exp=3", wdog_evt_cnt);
        end
`endif
    endtask

    task automatic test_recovery();
        int width = 1;
        int gap = 0;
        gen_done = 0;
        repeat (5) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || fault !== 1'b1) begin
                errors++;
                $display("FAIL fault_hold got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        gen_done = 1;
        force_reset = 1;
        tick();
        force_reset = 0;
        checks++;
        if (phy_reset_n !== 1'b0 || fault !== 1'b0 || retry_count !== 3'd0) begin
            errors++;
            $display("FAIL rec_enter phy=%b fault=%b retry=%0d exp 0 0 0", phy_reset_n, fault, retry_count);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rec_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (phy_reset_n === 1'b0) width++;
            else break;
        end
        checks++;
        if (width != 4) begin
            errors++;
            $display("FAIL rec_width got=%0d exp=4", width);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            gap++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rec_vec2 cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (phy_reset_n === 1'b0) break;
        end
        checks++;
        if (gap != R + T) begin
            errors++;
            $display("FAIL rec_to_next_pulse got=%0d exp=%0d", gap, R + T);
        end
    endtask

    task automatic test_tie_priority();
        int early_low = 0;
        do_reset();
        gen_done = 1;
        repeat (16) tick();
        rx_activity = 1;
        tick();
        rx_activity = 0;
        checks++;
        if (phy_reset_n !== 1'b1 || link_ok !== 1'b1) begin
            errors++;
            $display("FAIL tie_cancel phy=%b link=%b exp 1 1", phy_reset_n, link_ok);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL tie_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (phy_reset_n !== 1'b1) early_low++;
        end
        force_reset = 1; rx_activity = 1;
        tick();
        force_reset = 0; rx_activity = 0;
        checks++;
        if (early_low != 0 || phy_reset_n !== 1'b0 || link_ok !== 1'b0 || retry_count !== 3'd0) begin
            errors++;
            $display("FAIL force_over_act early=%0d phy=%b link=%b retry=%0d exp 0 0 0 0",
                     early_low, phy_reset_n, link_ok, retry_count);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL force_vec got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_disturb();
        int n = 0;
        do_reset();
        gen_done = 1;
        repeat (4) tick();
        force_reset = 1;
        tick();
        force_reset = 0;
        repeat (7) tick();
        gen_done = 0;
        repeat (3) tick();
        gen_done = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL dist_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (phy_reset_n === 1'b0) break;
        end
        checks++;
        if (n != T + 1) begin
            errors++;
            $display("FAIL dist_idle_restart got=%0d exp=%0d", n, T + 1);
        end
        tick();
        reset = 1;
        tick();
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 3'd0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_mid_pulse got=%h exp=%h", dut_vec(), {1'b1, 1'b0, 3'd0, 1'b0, 16'd0});
        end
        reset = 0;
    endtask

    task automatic test_random();
        int act_pct = 5;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) act_pct = $urandom_range(0, 12);
            if ($urandom_range(0, 99) < 2) gen_done = ~gen_done;
            rx_activity = ($urandom_range(0, 99) < act_pct);
            force_reset = ($urandom_range(0, 199) < 2);
            reset = ($urandom_range(0, 999) < 2);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        reset = 0; rx_activity = 0; force_reset = 0;
    endtask

    initial begin
        reset = 1; gen_done = 0; rx_activity = 0; force_reset = 0;
        m_phase = PH_IDLE; m_left = 0; m_retry = 0; m_evt = 0;
        m_link = 0; m_fault = 0; m_phy = 1;
        test_reset();
        test_power_up();
        test_keep_alive();
        test_exhaustion();
        test_recovery();
        test_tie_priority();
        test_disturb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enet_link_wdog.md
Name: enet_link_wdog

Overview:
- Ethernet PHY link watchdog; downstream companion to the power-on PHY reset generator, which drives this block's gen_done input.
- Once the generator releases the PHY, monitors receive activity.
- On prolonged silence or a software request, issues a timed active-low PHY reset pulse, waits out PHY recovery, and resumes monitoring.
- After a bounded number of consecutive failed retries, parks in a FAULT state and flags the fault.

Parameters:
- CNT_W, 24, width of the shared timing counter; must hold every *_CYCLES value.
- TIMEOUT_CYCLES, 12500000, cycles of silence before a watchdog reset is issued (0.5 s at 25 MHz).
- PULSE_CYCLES, 250000, number of cycles phy_reset_n is held low (10 ms).
- RECOVER_CYCLES, 2500000, post-pulse wait before monitoring resumes (100 ms).
- MAX_RETRY, 3, consecutive timeouts allowed before FAULT; range 1..7.

Ports:
- tx_clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- gen_done  in  1  high while the upstream reset generator has released the PHY.
- rx_activity  in  1  single-cycle strobe per received frame; already in the tx_clk domain.
- force_reset  in  1  software request for an immediate PHY reset (level; acted on when sampled).
- phy_reset_n  out  1  active-low PHY reset request, registered.
- link_ok  out  1  high after activity has been seen since the last (re)start of MONITOR.
- retry_count  out  3  consecutive timeout count.
- fault  out  1  retries exhausted.
- wdog_evt_cnt  out  16  timeout event count (optional feature only; otherwise 0).

Behaviour:
- Reset values: state IDLE, counter 0, phy_reset_n=1, link_ok=0, retry_count=0, fault=0, wdog_evt_cnt=0.
- States: IDLE, MONITOR, ASSERT, RECOVER, FAULT. All outputs are registered.
- IDLE:
  - counter held at 0.
  - gen_done=1 -> MONITOR next cycle.
- MONITOR:
  - counter increments each cycle.
  - rx_activity: counter:=0, link_ok:=1, retry_count:=0.
  - counter==TIMEOUT_CYCLES-1 with no activity this cycle, and retry_count<MAX_RETRY: -> ASSERT, retry_count+1, link_ok:=0.
  - Same timeout condition with retry_count==MAX_RETRY: -> FAULT, fault:=1.
  - force_reset: -> ASSERT; retry_count unchanged; link_ok:=0.
- ASSERT:
  - phy_reset_n goes 0 on the same edge that enters ASSERT.
  - phy_reset_n stays 0 for exactly PULSE_CYCLES cycles, then returns to 1 on the edge entering RECOVER.
- RECOVER:
  - lasts exactly RECOVER_CYCLES cycles, then -> MONITOR with counter 0.
- Activity handling: rx_activity is ignored in ASSERT and RECOVER.
- FAULT:
  - phy_reset_n=1, fault=1, link_ok=0.
  - Exits only via reset, or via force_reset -> ASSERT with retry_count:=0 and fault:=0.
- gen_done deassertion:
  - gen_done=0 in MONITOR or RECOVER -> IDLE next cycle; link_ok:=0; retry_count preserved.
  - In ASSERT, the pulse completes first, then IDLE.
  - FAULT ignores gen_done.
- Simultaneous-event priority:
  - reset > gen_done drop > force_reset > rx_activity > timeout.
  - Activity on the timeout cycle cancels the timeout.
- Counter: a single CNT_W counter is reused per state and cleared on every state change. It never wraps in normal operation; terminal compares are equality.
- Reset mid-pulse: phy_reset_n returns to 1 on the reset edge.

Optional Feature:
- Macro: ENET_WDOG_EVT_CNT_EN.
- Defined:
  - wdog_evt_cnt increments on every MONITOR timeout (including the one that enters FAULT); force_reset is not counted.
  - Saturates at 16'hFFFF. Cleared only by reset.
- Undefined:
  - Counter logic is absent; wdog_evt_cnt is tied to 0.
  - Port list is unchanged.

Decomposition:
- Shared package enet_wdog_pkg holds:
  - the state enum type;
  - the retry_count width constant (3);
  - the event-counter width constant (16).
- Sub-module enet_wdog_timer (load/clear, increment, terminal-compare) is natural and reused per state. Everything else stays inline.

Test Plan:
All tests use TIMEOUT_CYCLES=16, PULSE_CYCLES=4, RECOVER_CYCLES=8, MAX_RETRY=2.
- Power-up: reset high 3 cycles, then gen_done=1, no activity -> phy_reset_n low exactly 4 cycles starting 17 cycles after MONITOR entry; retry_count=1.
- Keep-alive: rx_activity every 10 cycles for 200 cycles -> phy_reset_n stays 1, link_ok=1 from the first strobe, retry_count=0.
- Exhaustion: permanent silence -> two pulses, then FAULT on the third timeout; fault=1, phy_reset_n=1; with macro defined, wdog_evt_cnt=3.
- Recovery: in FAULT, pulse force_reset for 1 cycle -> ASSERT next edge, fault=0, retry_count=0, 4-cycle pulse, MONITOR after 8 further cycles.
- Tie and priority: rx_activity on counter==15 -> no pulse, counter restarts. force_reset and rx_activity in the same cycle -> pulse issued.
- Disturbances: gen_done dropped mid-RECOVER -> IDLE next cycle. reset asserted mid-ASSERT -> phy_reset_n=1 on that edge and all outputs at reset values.
